sd_spi_cmd_ctrl: RTL

SPI-mode SD-card command sequencer that owns the SD pins on the JC header (SCK, CMD/MOSI, MISO) plus chip-select. It performs the power-up clocking sequence and issues 48-bit commands with generated CRC7. It collects the R1 response and, for read commands, streams one 512-byte data block to the requester. It sits between the system-side SD interface logic and the physical pins, and is the only driver of SCK/MOSI/CS.

---
 rtl/sd_spi_cmd_ctrl_pkg.sv | 39 +++
 rtl/sd_crc7.sv | 38 +++
 rtl/sd_spi_cmd_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_cmd_ctrl_pkg.sv
// Shared types and constants for the SPI-mode SD command sequencer.
// States, error codes, token/length constants and frame helper.
package sd_spi_cmd_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_CMD_TX,
        ST_R1_WAIT,
        ST_TOKEN_WAIT,
        ST_DATA_RX,
        ST_CRC_RX,
        ST_TRAIL,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK            = 2'd0,
        ERR_R1_TIMEOUT    = 2'd1,
        ERR_TOKEN_TIMEOUT = 2'd2,
        ERR_TOKEN         = 2'd3
    } err_e;

    localparam logic [7:0] START_TOKEN  = 8'hFE;
    localparam int         BLOCK_BYTES  = 512;
    localparam int         INIT_CLOCKS  = 80;
    localparam int         TRAIL_CLOCKS = 8;
    localparam int         CRC_BYTES    = 2;
    localparam int         CMD_BYTES    = 6;
    localparam int         CRC_SPAN     = 40;

    function automatic logic [39:0] cmd_frame(
        input logic [5:0]  idx,
        input logic [31:0] arg
    );
        return {2'b01, idx, arg};
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), initial value zero.
// Advanced one bit per enable, cleared before each command.
module sd_crc7 (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    // next CRC state from clear / shift-in
    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = crc_q;
        if (clr) begin
            crc_d = 7'd0;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
        end
    end

    // CRC register
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            crc_q <= 7'd0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_spi_cmd_ctrl.sv
// SPI-mode SD command sequencer: power-up clocks, CMD + CRC7,
// R1 collection and single 512-byte block read.
import sd_spi_cmd_ctrl_pkg::*;

module sd_spi_cmd_ctrl #(
    parameter int CLK_DIV       = 125,
    parameter int R1_TIMEOUT    = 8,
    parameter int TOKEN_TIMEOUT = 4096
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        init_req,
    input  logic        cmd_req,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_read,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic [1:0]  err,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        SD_SCK,
    output logic        SD_MOSI,
    output logic        SD_CS_N,
    input  logic        SD_MISO
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int M1 = (TOKEN_TIMEOUT > BLOCK_BYTES) ? TOKEN_TIMEOUT : BLOCK_BYTES;
    localparam int BMAX = (R1_TIMEOUT > M1) ? R1_TIMEOUT : M1;
    localparam int BW = $clog2(BMAX + 1);
    localparam int INIT_BYTES = INIT_CLOCKS / 8;
    localparam int TRAIL_BYTES = TRAIL_CLOCKS / 8;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW+2:0] NB_CRC = (BW+3)'(CRC_SPAN);

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic [3:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [47:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          rd_q, rd_d;
    logic [7:0]    r1_q, r1_d;
    logic [1:0]    err_q, err_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;

    logic          active;
    logic          tick;
    logic          rise;
    logic          fall;
    logic          byte_end;
    logic [BW+2:0] nbit;
    logic          crc_clr;
    logic          crc_en;
    logic [6:0]    crc;

    sd_crc7 u_crc7 (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .clr        (crc_clr),
        .en         (crc_en),
        .din        (mosi_q),
        .crc        (crc)
    );

    // Sequencer: SCK divider, bit/byte engine and state decisions.
    // Bits are counted on SCK rise; state changes on the fall after
    // the 8th rise so CS/MOSI never move while SCK is high.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        r1_d    = r1_q;
        err_d   = err_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        crc_clr = 1'b0;
        crc_en  = 1'b0;

        active   = (state_q != ST_IDLE) && (state_q != ST_DONE);
        tick     = active && (div_q == DIV_LAST);
        rise     = tick && !sck_q;
        fall     = tick && sck_q;
        byte_end = fall && (bit_q == 4'd8);
        nbit     = {byte_q, 3'b000} + (BW+3)'(bit_q);

        if (active) begin
            div_d = tick ? '0 : div_q + 1'b1;
            sck_d = tick ? ~sck_q : sck_q;
        end
        if (rise) begin
            rx_d  = {rx_q[6:0], SD_MISO};
            bit_d = bit_q + 4'd1;
        end
        if (byte_end) begin
            bit_d  = 4'd0;
            byte_d = byte_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                end else if (cmd_req) begin
                    state_d = ST_CMD_TX;
                    tx_d    = {cmd_frame(cmd_index, cmd_arg), 8'hFF};
                    rd_d    = cmd_read;
                    r1_d    = 8'hFF;
                    err_d   = ERR_OK;
                    crc_clr = 1'b1;
                end
            end
            ST_INIT: begin
                if (byte_end && byte_q == BW'(INIT_BYTES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_CMD_TX: begin
                crc_en = rise && (nbit < NB_CRC);
                if (fall) begin
                    if (nbit == NB_CRC) begin
                        tx_d = {crc, 1'b1, 40'd0};
                    end else begin
                        tx_d = tx_q << 1;
                    end
                end
                if (byte_end && byte_q == BW'(CMD_BYTES - 1)) begin
                    state_d = ST_R1_WAIT;
                end
            end
            ST_R1_WAIT: begin
                if (byte_end) begin
                    if (!rx_q[7]) begin
                        r1_d = rx_q;
                        if (rd_q && rx_q[6:1] == 6'd0) begin
                            state_d = ST_TOKEN_WAIT;
                        end else begin
                            state_d = ST_TRAIL;
                        end
                    end else if (byte_q == BW'(R1_TIMEOUT - 1)) begin
                        err_d   = ERR_R1_TIMEOUT;
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_TOKEN_WAIT: begin
                if (byte_end) begin
                    if (rx_q == START_TOKEN) begin
                        state_d = ST_DATA_RX;
                    end else if (rx_q[7:4] == 4'd0) begin
                        err_d   = ERR_TOKEN;
                        state_d = ST_TRAIL;
                    end else if (byte_q == BW'(TOKEN_TIMEOUT - 1)) begin
                        err_d   = ERR_TOKEN_TIMEOUT;
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_DATA_RX: begin
                if (rise && bit_q == 4'd7) begin
                    data_d = {rx_q[6:0], SD_MISO};
                    dv_d   = 1'b1;
                end
                if (byte_end && byte_q == BW'(BLOCK_BYTES - 1)) begin
                    state_d = ST_CRC_RX;
                end
            end
            ST_CRC_RX: begin
                if (byte_end && byte_q == BW'(CRC_BYTES - 1)) begin
                    state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (byte_end && byte_q == BW'(TRAIL_BYTES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            bit_d  = 4'd0;
            byte_d = '0;
        end
        if (!active || state_d == ST_IDLE || state_d == ST_DONE) begin
            div_d = '0;
        end
        if (state_d == ST_IDLE || state_d == ST_DONE) begin
            sck_d = 1'b0;
        end
        cs_n_d = !(state_d inside {ST_CMD_TX, ST_R1_WAIT, ST_TOKEN_WAIT,
                                   ST_DATA_RX, ST_CRC_RX});
        mosi_d = (state_d == ST_CMD_TX) ? tx_d[47] : 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            bit_q   <= 4'd0;
            byte_q  <= '0;
            tx_q    <= '0;
            rx_q    <= 8'd0;
            rd_q    <= 1'b0;
            r1_q    <= 8'hFF;
            err_q   <= ERR_OK;
            data_q  <= 8'd0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            r1_q    <= r1_d;
            err_q   <= err_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
        end
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign r1         = r1_q;
    assign err        = err_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign SD_SCK     = sck_q;
    assign SD_MOSI    = mosi_q;
    assign SD_CS_N    = cs_n_q;

endmodule
